ps2_keyboard_decoder: RTL and testbench

//  PS/2 keyboard receiver: syncs and filters raw PS/2 clock/data, deframes 11-bit device->host frames,

---
 rtl/ps2_keyboard_decoder.sv | 145 ++++++++++++++
 tb/tb_ps2_keyboard_decoder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 pins, deframes device->host
// frames, tracks scan code set 2 prefixes and shift state, and maps key events to ASCII.
module ps2_keyboard_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic [7:0] scan_code,
  output logic [7:0] ascii_code,
  output logic       key_pressed,
  output logic       key_released
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt, clk_filt_q;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] timer;
  logic          byte_rdy;
  logic [7:0]    byte_val;

  logic          brk_flag, ext_flag, shift_flag;

  function automatic logic [7:0] ascii_map(input logic [7:0] code, input logic shift);
    logic [7:0] a;
    a = '0;
    case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;  8'h76: a = 8'h1B;
      8'h0D: a = 8'h09;
      default: a = '0;
    endcase
    // Shift only affects letters; digits and control codes are unchanged.
    if (shift && a >= 8'h61 && a <= 8'h7A)
      a = a - 8'h20;
    return a;
  endfunction

  assign fall = clk_filt_q & ~clk_filt;

  // Pin synchronisers and clock glitch filter; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync   <= '1;
      data_sync  <= '1;
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk_async};
      data_sync  <= {data_sync[0], ps2_data_async};
      clk_filt_q <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Deframer: an edge takes priority over an expiring timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      timer    <= '0;
      byte_rdy <= 1'b0;
      byte_val <= '0;
    end else begin
      byte_rdy <= 1'b0;
      if (fall) begin
        timer <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt  <= '0;
          byte_val <= shreg[8:1];
          byte_rdy <= ~shreg[0] & data_sync[1] & (^shreg[9:1]);
        end else begin
          shreg   <= {data_sync[1], shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt <= '0;
          timer   <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_code    <= '0;
      ascii_code   <= '0;
      key_pressed  <= 1'b0;
      key_released <= 1'b0;
      brk_flag     <= 1'b0;
      ext_flag     <= 1'b0;
      shift_flag   <= 1'b0;
    end else begin
      key_released <= 1'b0;
      if (byte_rdy) begin
        if (byte_val == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (byte_val == 8'hF0) begin
          brk_flag <= 1'b1;
        end else begin
          if (byte_val == 8'h12 || byte_val == 8'h59)
            shift_flag <= ~brk_flag;
          scan_code    <= byte_val;
          ascii_code   <= ext_flag ? 8'h00 : ascii_map(byte_val, shift_flag);
          key_pressed  <= ~brk_flag;
          key_released <= brk_flag;
          brk_flag     <= 1'b0;
          ext_flag     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench for ps2_keyboard_decoder: drives PS/2 frames bit by bit and checks
// decoded outputs against a queue of expected key-event results.
module tb_ps2_keyboard_decoder;

  localparam int unsigned TMO  = 2000;
  localparam int unsigned HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk_async;
  logic       ps2_data_async;
  logic [7:0] scan_code;
  logic [7:0] ascii_code;
  logic       key_pressed;
  logic       key_released;

  typedef struct {
    logic [7:0] scan;
    logic [7:0] ascii;
    logic       pressed;
    int         rel;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   rel_cycles = 0;

  ps2_keyboard_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .ps2_clk_async  (ps2_clk_async),
    .ps2_data_async (ps2_data_async),
    .scan_code      (scan_code),
    .ascii_code     (ascii_code),
    .key_pressed    (key_pressed),
    .key_released   (key_released)
  );

  always #10 clk = ~clk;

  // Total cycles key_released was high; each break event must add exactly one.
  always @(posedge clk) if (key_released === 1'b1) rel_cycles <= rel_cycles + 1;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data_async = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk_async = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk_async = 1'b1;
    end
    @(negedge clk) ps2_data_async = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] s, input logic [7:0] a, input logic p, input int r);
    exp_t e;
    e.scan = s; e.ascii = a; e.pressed = p; e.rel = r;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s: observed empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      @(negedge clk);
      chk({tag, ".scan"},    scan_code,   e.scan);
      chk({tag, ".ascii"},   ascii_code,  e.ascii);
      chk({tag, ".pressed"}, key_pressed, e.pressed);
      chk({tag, ".rel"},     rel_cycles,  e.rel);
    end
  endtask

  initial begin
    reset = 1'b1;
    ps2_clk_async = 1'b1;
    ps2_data_async = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.scan", scan_code, 0);
    chk("rst.ascii", ascii_code, 0);
    chk("rst.pressed", key_pressed, 0);
    chk("rst.released", key_released, 0);

    push(8'h1C, 8'h61, 1'b1, 0); send_frame(8'h1C, 1'b0, 11); pop_check("make_a");
    send_frame(8'hF0, 1'b0, 11);
    push(8'h1C, 8'h61, 1'b0, 1); send_frame(8'h1C, 1'b0, 11); pop_check("break_a");

    push(8'h12, 8'h00, 1'b1, 1); send_frame(8'h12, 1'b0, 11); pop_check("lshift_make");
    push(8'h1C, 8'h41, 1'b1, 1); send_frame(8'h1C, 1'b0, 11); pop_check("shift_A");
    send_frame(8'hF0, 1'b0, 11);
    push(8'h12, 8'h00, 1'b0, 2); send_frame(8'h12, 1'b0, 11); pop_check("lshift_break");
    push(8'h1C, 8'h61, 1'b1, 2); send_frame(8'h1C, 1'b0, 11); pop_check("unshift_a");

    push(8'h1C, 8'h61, 1'b1, 2); send_frame(8'h16, 1'b1, 11); pop_check("bad_parity");
    push(8'h16, 8'h31, 1'b1, 2); send_frame(8'h16, 1'b0, 11); pop_check("digit_1");

    send_frame(8'h55, 1'b0, 5);
    repeat (TMO + 500) @(negedge clk);
    push(8'h29, 8'h20, 1'b1, 2); send_frame(8'h29, 1'b0, 11); pop_check("timeout_space");

    send_frame(8'hE0, 1'b0, 11);
    push(8'h75, 8'h00, 1'b1, 2); send_frame(8'h75, 1'b0, 11); pop_check("ext_up");
    push(8'h5A, 8'h0D, 1'b1, 2); send_frame(8'h5A, 1'b0, 11); pop_check("enter");

    send_frame(8'h33, 1'b0, 5);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push(8'h00, 8'h00, 1'b0, 2); pop_check("mid_reset");
    push(8'h1C, 8'h61, 1'b1, 2); send_frame(8'h1C, 1'b0, 11); pop_check("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
